// File: rtl/adis16209_pkg.sv
// adis16209_pkg: state encodings, register addresses and read-frame helper for the ADIS16209 poller
package adis16209_pkg;
  localparam logic [6:0] X_ADDR = 7'h0C;
  localparam logic [6:0] Y_ADDR = 7'h0E;
  localparam logic [6:0] T_ADDR = 7'h0A;
  typedef enum logic [3:0] {
    S_IDLE, S_CFG0, S_CFG1, S_RD_X, S_RD_Y, S_RD_T, S_RD_FLUSH, S_PUBLISH, S_WAIT_PER
  } state_e;
  typedef enum logic [1:0] {F_IDLE, F_STALL, F_WAIT} fstate_e;
  function automatic logic [15:0] read_frame(input logic [6:0] addr);
    return {1'b0, addr, 8'h00};
  endfunction
endpackage

// File: rtl/adis_frame_issuer.sv
// adis_frame_issuer: stall wait, one-cycle spi_req, hold until done or timeout
module adis_frame_issuer
  import adis16209_pkg::*;
#(
  parameter int STALL_CYC   = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active_i,
  input  logic        wr_i,
  input  logic [15:0] data_i,
  input  logic        spi_done_i,
  output logic        spi_req_o,
  output logic        spi_wr_en_o,
  output logic [15:0] spi_data_tx_o,
  output logic        done_o,
  output logic        tmo_o
);
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  fstate_e st_q;
  logic [SW-1:0] stall_q;
  logic [TW-1:0] tmo_q;
  assign done_o = (st_q == F_WAIT) && spi_done_i;
  assign tmo_o  = (st_q == F_WAIT) && !spi_done_i && (tmo_q == TW'(TIMEOUT_CYC));
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= F_IDLE;
      stall_q       <= '0;
      tmo_q         <= '0;
      spi_req_o     <= 1'b0;
      spi_wr_en_o   <= 1'b0;
      spi_data_tx_o <= '0;
    end else begin
      spi_req_o <= 1'b0;
      unique case (st_q)
        F_IDLE: if (active_i) begin
          st_q    <= F_STALL;
          stall_q <= '0;
        end
        F_STALL: if (stall_q == SW'(STALL_CYC - 1)) begin
          st_q          <= F_WAIT;
          tmo_q         <= '0;
          spi_req_o     <= 1'b1;
          spi_wr_en_o   <= wr_i;
          spi_data_tx_o <= data_i;
        end else stall_q <= stall_q + 1'b1;
        F_WAIT: if (done_o || tmo_o) st_q <= F_IDLE;
          else if (tmo_q != TW'(TIMEOUT_CYC)) tmo_q <= tmo_q + 1'b1;
        default: st_q <= F_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/adis16209_poll_ctrl.sv
// adis16209_poll_ctrl: configures the ADIS16209 then publishes periodic realigned {x,y,temp} samples
module adis16209_poll_ctrl
  import adis16209_pkg::*;
#(
  parameter logic [15:0] CFG0_FRAME  = 16'h0004,
  parameter logic [15:0] CFG1_FRAME  = 16'h7000,
  parameter int          STALL_CYC   = 64,
  parameter int          PERIOD_CYC  = 420000,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        spi_req,
  output logic        spi_wr_en,
  output logic [15:0] spi_data_tx,
  input  logic        spi_done,
  input  logic [15:0] spi_data_rx,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] temp_data,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);
  localparam int PW = $clog2(PERIOD_CYC + 1);
  state_e state_q;
  logic cfg_done_q, en_q, f_done, f_tmo, frame_act, frame_wr;
  logic [PW-1:0] per_q;
  logic [15:0] xs_q, ys_q, frame_tx;
  assign frame_act = state_q inside {S_CFG0, S_CFG1, S_RD_X, S_RD_Y, S_RD_T, S_RD_FLUSH};
  assign frame_wr  = state_q inside {S_CFG0, S_CFG1};
  assign busy      = (state_q != S_IDLE) && (state_q != S_WAIT_PER);
  always_comb
    frame_tx = state_q == S_CFG0 ? CFG0_FRAME :
               state_q == S_CFG1 ? CFG1_FRAME :
               state_q == S_RD_X ? read_frame(X_ADDR) :
               state_q == S_RD_Y ? read_frame(Y_ADDR) : read_frame(T_ADDR);
  adis_frame_issuer #(.STALL_CYC(STALL_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_issuer (
    .clk          (clk),
    .rst          (rst),
    .active_i     (frame_act),
    .wr_i         (frame_wr),
    .data_i       (frame_tx),
    .spi_done_i   (spi_done),
    .spi_req_o    (spi_req),
    .spi_wr_en_o  (spi_wr_en),
    .spi_data_tx_o(spi_data_tx),
    .done_o       (f_done),
    .tmo_o        (f_tmo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cfg_done_q   <= 1'b0;
      en_q         <= 1'b0;
      per_q        <= '0;
      xs_q         <= '0;
      ys_q         <= '0;
      x_data       <= '0;
      y_data       <= '0;
      temp_data    <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      en_q         <= enable;
      sample_valid <= 1'b0;
      if (per_q != PW'(PERIOD_CYC)) per_q <= per_q + 1'b1;
      if (enable && !en_q) timeout_err <= 1'b0;
      if (f_tmo) begin
        state_q     <= S_IDLE;
        timeout_err <= 1'b1;
        xs_q        <= '0;
        ys_q        <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: if (enable && !timeout_err) begin
            state_q <= cfg_done_q ? S_RD_X : S_CFG0;
            per_q   <= '0;
          end
          S_CFG0: if (f_done) state_q <= S_CFG1;
          S_CFG1: if (f_done) begin
            state_q    <= S_RD_X;
            cfg_done_q <= 1'b1;
            per_q      <= '0;
          end
          S_RD_X: if (f_done) state_q <= S_RD_Y;
          S_RD_Y: if (f_done) begin
            state_q <= S_RD_T;
            xs_q    <= spi_data_rx;
          end
          S_RD_T: if (f_done) begin
            state_q <= S_RD_FLUSH;
            ys_q    <= spi_data_rx;
          end
          S_RD_FLUSH: if (f_done) begin
            state_q      <= S_PUBLISH;
            x_data       <= xs_q;
            y_data       <= ys_q;
            temp_data    <= spi_data_rx;
            sample_valid <= 1'b1;
          end
          S_PUBLISH: state_q <= S_WAIT_PER;
          S_WAIT_PER: if (per_q >= PW'(PERIOD_CYC - 1)) begin
            state_q <= enable ? S_RD_X : S_IDLE;
            per_q   <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
